// File: rtl/result_display_pkg.sv
// Shared definitions for the result display block: register map, CTRL layout
// and handshake state encoding.
package result_display_pkg;

  localparam logic [1:0] ADDR_VALUE  = 2'd0;
  localparam logic [1:0] ADDR_LED    = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_BLANK_LSB = 8;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Hex nibble to seven-segment pattern, bit order {g,f,e,d,c,b,a}, active-low.
module seg7_hex_decode (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/result_display.sv
// CPU-facing result display: register file, pending/ack handshake and a
// multiplexed 8-digit seven-segment scan engine.
module result_display
  import result_display_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DIGITS   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [1:0]        wr_addr,
  input  logic [31:0]       wr_data,
  input  logic [1:0]        rd_addr,
  output logic [31:0]       rd_data,
  input  logic              ack,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic [15:0]       led,
  output logic              pending
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [31:0]       value_q;
  logic [15:0]       led_q;
  logic              ctrl_en;
  logic [DIGITS-1:0] ctrl_blank;
  state_t            state;
  logic              ack_q;
  logic [DW-1:0]     div_cnt;
  logic [IW-1:0]     digit_idx;

  logic       div_wrap;
  logic       ack_edge;
  logic       value_wr;
  logic       slot_on;
  logic [3:0] nibble;
  logic [6:0] hex_seg;

  assign led      = led_q;
  assign div_wrap = (div_cnt == DIV_LAST);
  assign ack_edge = ack & ~ack_q;
  assign value_wr = wr_en && (wr_addr == ADDR_VALUE);
  assign slot_on  = ctrl_en & ~ctrl_blank[digit_idx];
  assign nibble   = value_q[{digit_idx, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .hex (nibble),
    .seg (hex_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q    <= '0;
      led_q      <= '0;
      ctrl_en    <= 1'b0;
      ctrl_blank <= '0;
    end else if (wr_en) begin
      case (wr_addr)
        ADDR_VALUE: value_q <= wr_data;
        ADDR_LED:   led_q   <= wr_data[15:0];
        ADDR_CTRL: begin
          ctrl_en    <= wr_data[CTRL_EN_BIT];
          ctrl_blank <= wr_data[CTRL_BLANK_LSB +: DIGITS];
        end
        default: ;
      endcase
    end
  end

  // A VALUE write always wins over a simultaneous ack edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pending <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= ack;
      case (state)
        IDLE: begin
          if (value_wr) begin
            state   <= PEND;
            pending <= 1'b1;
          end
        end
        PEND: begin
          if (value_wr) begin
            state   <= PEND;
            pending <= 1'b1;
          end else if (ack_edge) begin
            state   <= IDLE;
            pending <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          pending <= 1'b0;
        end
      endcase
    end
  end

  // On each wrap the slot for the current index is loaded and the index advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt   <= '0;
      digit_idx <= '0;
      seg       <= 8'hFF;
      an        <= '1;
    end else if (div_wrap) begin
      div_cnt   <= '0;
      digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
      if (slot_on) begin
        an  <= ~(DIGITS'(1) << digit_idx);
        seg <= {~((digit_idx == '0) && (state == PEND)), hex_seg};
      end else begin
        an  <= '1;
        seg <= 8'hFF;
      end
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      ADDR_VALUE:  rd_data = value_q;
      ADDR_LED:    rd_data = {16'h0000, led_q};
      ADDR_CTRL:   rd_data = {16'h0000, ctrl_blank, 7'b0000000, ctrl_en};
      ADDR_STATUS: rd_data = {30'b0, (state == PEND), pending};
      default:     rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_result_display.sv
// Randomized scoreboard bench for result_display against a cycle-count based
// behavioural model of the register file, handshake and digit scan.
module tb_result_display;

  localparam int SCAN_DIV = 4;
  localparam int DIGITS   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  rd_addr;
  logic [31:0] rd_data;
  logic        ack;
  logic [7:0]  seg;
  logic [7:0]  an;
  logic [15:0] led;
  logic        pending;

  int checks = 0;
  int errors = 0;

  result_display #(.SCAN_DIV(SCAN_DIV), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .ack     (ack),
    .seg     (seg),
    .an      (an),
    .led     (led),
    .pending (pending)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural model: slot timing derived from the cycle count since reset
  logic [6:0]  hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [31:0] m_value, m_ctrl;
  logic [15:0] m_led;
  logic        m_pend, m_ackq;
  logic [7:0]  m_an, m_seg;
  int          m_cyc;
  logic [32:0] exp_q[$];

  initial begin
    int   slot;
    logic ack_edge;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_value = '0; m_ctrl = '0; m_led = '0; m_pend = 1'b0; m_ackq = 1'b0;
        m_an = 8'hFF; m_seg = 8'hFF; m_cyc = 0;
      end else begin
        ack_edge = ack && !m_ackq;
        if ((m_cyc % SCAN_DIV) == SCAN_DIV - 1) begin
          slot = (m_cyc / SCAN_DIV) % DIGITS;
          if (m_ctrl[0] && !m_ctrl[8 + slot]) begin
            m_an       = 8'hFF;
            m_an[slot] = 1'b0;
            m_seg      = {!(slot == 0 && m_pend), hex_tbl[m_value[slot*4 +: 4]]};
          end else begin
            m_an  = 8'hFF;
            m_seg = 8'hFF;
          end
        end
        if (wr_en) begin
          case (wr_addr)
            2'd0: m_value = wr_data;
            2'd1: m_led   = wr_data[15:0];
            2'd2: m_ctrl  = wr_data & 32'h0000_FF01;
            default: ;
          endcase
        end
        if (wr_en && wr_addr == 2'd0) m_pend = 1'b1;
        else if (ack_edge)            m_pend = 1'b0;
        m_ackq = ack;
        m_cyc++;
      end
      exp_q.push_back({m_pend, m_led, m_an, m_seg});
    end
  end

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0:    return m_value;
      2'd1:    return {16'h0000, m_led};
      2'd2:    return m_ctrl;
      default: return {30'b0, m_pend, m_pend};
    endcase
  endfunction

  // scoreboard monitor
  initial begin
    logic [32:0] exp_v, act_v;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        if (!rst) begin
          act_v = {pending, led, an, seg};
          checks++;
          if (act_v !== exp_v) begin
            errors++;
            $display("FAIL outputs t=%0t: got pend=%b led=%h an=%h seg=%h, expected pend=%b led=%h an=%h seg=%h",
                     $time, act_v[32], act_v[31:16], act_v[15:8], act_v[7:0],
                     exp_v[32], exp_v[31:16], exp_v[15:8], exp_v[7:0]);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    cyc(1);
    wr_en = 1'b0;
  endtask

  task automatic rd_check(input logic [1:0] a);
    rd_addr = a;
    #1;
    chk($sformatf("rd_addr%0d", a), rd_data, model_rd(a));
  endtask

  task automatic reset_check();
    rst = 1'b1;
    #1;
    chk("rst_seg", {24'h0, seg}, 32'h0000_00FF);
    chk("rst_an", {24'h0, an}, 32'h0000_00FF);
    chk("rst_led", {16'h0, led}, 32'h0);
    chk("rst_pending", {31'h0, pending}, 32'h0);
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      #1;
      chk("rst_rd", rd_data, 32'h0);
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0; ack = 1'b0;
    cyc(2);
    reset_check();
    cyc(1);
    rst = 1'b0;

    // basic scan of a known value
    wr(2'd2, 32'h0000_0001);
    wr(2'd0, 32'h1234_ABCD);
    chk("pend_after_write", {31'h0, pending}, 32'h1);
    rd_check(2'd3);
    cyc(40);

    // ack edge clears; held ack does not acknowledge a new write
    ack = 1'b1;
    cyc(1);
    chk("pend_after_ack", {31'h0, pending}, 32'h0);
    rd_check(2'd3);
    wr(2'd0, 32'h0000_0005);
    cyc(6);
    chk("pend_ack_held", {31'h0, pending}, 32'h1);
    ack = 1'b0;
    cyc(2);
    chk("pend_ack_low", {31'h0, pending}, 32'h1);
    ack = 1'b1;
    cyc(1);
    chk("pend_fresh_edge", {31'h0, pending}, 32'h0);

    // write coinciding with an ack edge
    ack = 1'b0;
    wr(2'd0, 32'h0BAD_F00D);
    ack = 1'b1;
    wr(2'd0, 32'hCAFE_0042);
    chk("pend_write_wins", {31'h0, pending}, 32'h1);
    rd_addr = 2'd0;
    #1;
    chk("value_write_wins", rd_data, 32'hCAFE_0042);
    ack = 1'b0;

    // blank mask, then display disable
    wr(2'd2, 32'h0000_0F01);
    rd_check(2'd2);
    cyc(40);
    wr(2'd2, 32'h0000_0000);
    cyc(40);
    wr(2'd2, 32'h0000_0001);

    // LED upper bits dropped; STATUS write ignored
    wr(2'd1, 32'hFFFF_A5A5);
    chk("led_value", {16'h0, led}, 32'h0000_A5A5);
    rd_addr = 2'd1;
    #1;
    chk("led_read", rd_data, 32'h0000_A5A5);
    wr(2'd3, 32'hFFFF_FFFF);
    rd_check(2'd3);
    rd_check(2'd0);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) ack = ~ack;
      if ($urandom_range(0, 9) < 2) begin
        wr_en   = 1'b1;
        wr_addr = 2'($urandom_range(0, 3));
        wr_data = $urandom;
        if (wr_addr == 2'd2 && $urandom_range(0, 1) == 1) wr_data[0] = 1'b1;
      end
      cyc(1);
      wr_en = 1'b0;
      if ($urandom_range(0, 7) == 0) rd_check(2'($urandom_range(0, 3)));
    end

    // reset in the middle of a scan with a result pending
    ack = 1'b0;
    wr(2'd2, 32'h0000_0001);
    wr(2'd0, 32'h8888_8888);
    cyc(7);
    reset_check();
    cyc(2);
    rst = 1'b0;
    cyc(20);
    rd_check(2'd2);
    cyc(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
